// File: rtl/fp_fcl_pkg.sv
// Shared types and constants for the fully-connected PE array sequencer.
// The default lane geometry lives here so helpers and the top agree on it.
package fp_fcl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_CAPTURE = 2'd3
   } fcl_state_t;

   localparam int DRAIN_CYC = 2;
   localparam int RD_LAT    = 1;

   localparam int PAR_DEF = 4;
   localparam int DW_DEF  = 8;

   // Lane idx of a packed PAR_DEF x DW_DEF bus, lane 0 in the low bits.
   function automatic logic [DW_DEF-1:0] lane_of(input logic [PAR_DEF*DW_DEF-1:0] vec,
                                                 input int idx);
      return vec[idx*DW_DEF +: DW_DEF];
   endfunction

endpackage

// File: rtl/fp_fcl_res_buf.sv
// One-entry result register on a valid/ready port. A new word may be loaded
// in the same cycle the held word is accepted, so back-to-back jobs never stall.
module fp_fcl_res_buf #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   output logic         can_load_o,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   // Handshake: a word transfers on any edge where valid_o && ready_i; valid_o
   // never drops and data_o never changes while valid_o is high and ready_i low.
   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;

   assign can_load_o = ~valid_q | ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fp_fcl_ctrl.sv
// Sequencer for the fixed-point fully-connected PE array: fetches a vector and
// its weights, streams them into the array and buffers the lane sums.
module fp_fcl_ctrl
   import fp_fcl_pkg::*;
#(
   parameter int PAR       = PAR_DEF,
   parameter int DATAWIDTH = DW_DEF,
   parameter int MAX_LEN   = 256,
   parameter int ADDR_W    = $clog2(MAX_LEN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_W:0]          len,
   output logic                     busy,
   output logic                     act_rd_en,
   output logic [ADDR_W-1:0]        act_rd_addr,
   input  logic [DATAWIDTH-1:0]     act_rd_data,
   output logic                     w_rd_en,
   output logic [ADDR_W-1:0]        w_rd_addr,
   input  logic [PAR*DATAWIDTH-1:0] w_rd_data,
   output logic [DATAWIDTH-1:0]     pe_in,
   output logic [PAR*DATAWIDTH-1:0] pe_w,
   output logic                     pe_load_n,
   input  logic [PAR*DATAWIDTH-1:0] pe_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [PAR*DATAWIDTH-1:0] res_data,
   output logic [1:0]               dbg_state_o
);

   localparam int LEN_W  = ADDR_W + 1;
   localparam int BUS_W  = PAR * DATAWIDTH;
   localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

   fcl_state_t        state_q, state_d;
   logic [LEN_W-1:0]  len_q,   len_d;
   logic [ADDR_W-1:0] cnt_q,   cnt_d;
   logic [DCNT_W-1:0] dcnt_q,  dcnt_d;

   logic start_ok;
   logic last_elem;
   logic fetch;
   logic rd_first;
   logic cap_load;
   logic buf_can_load;

   // Read-data valid/first flags, delayed by the RAM read latency.
   logic [RD_LAT-1:0] vld_sr_q;
   logic [RD_LAT-1:0] first_sr_q;

   logic [DATAWIDTH-1:0] pe_in_q;
   logic [BUS_W-1:0]     pe_w_q;
   logic                 pe_load_n_q;

   assign start_ok  = start && (len != '0) && (len <= LEN_W'(MAX_LEN));
   assign last_elem = ({1'b0, cnt_q} == (len_q - LEN_W'(1)));
   assign fetch     = (state_q == ST_FETCH);
   assign rd_first  = fetch && (cnt_q == '0);

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      dcnt_d   = dcnt_q;
      cap_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_FETCH;
               len_d   = len;
               cnt_d   = '0;
            end
         end
         ST_FETCH: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (last_elem) begin
               state_d = ST_DRAIN;
               dcnt_d  = '0;
            end
         end
         ST_DRAIN: begin
            if (dcnt_q == DCNT_W'(DRAIN_CYC - 1)) begin
               state_d = ST_CAPTURE;
            end else begin
               dcnt_d = dcnt_q + DCNT_W'(1);
            end
         end
         ST_CAPTURE: begin
            // The array holds its sum while inputs are zero, so waiting is free.
            if (buf_can_load) begin
               cap_load = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         dcnt_q  <= dcnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_sr_q    <= '0;
         first_sr_q  <= '0;
         pe_in_q     <= '0;
         pe_w_q      <= '0;
         pe_load_n_q <= 1'b1;
      end else begin
         vld_sr_q    <= RD_LAT'({vld_sr_q, fetch});
         first_sr_q  <= RD_LAT'({first_sr_q, rd_first});
         pe_in_q     <= vld_sr_q[RD_LAT-1] ? act_rd_data : '0;
         pe_w_q      <= vld_sr_q[RD_LAT-1] ? w_rd_data   : '0;
         pe_load_n_q <= ~(vld_sr_q[RD_LAT-1] & first_sr_q[RD_LAT-1]);
      end
   end

   fp_fcl_res_buf #(
      .W (BUS_W)
   ) u_res_buf (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cap_load),
      .data_i     (pe_out),
      .can_load_o (buf_can_load),
      .valid_o    (res_valid),
      .ready_i    (res_ready),
      .data_o     (res_data)
   );

   assign busy        = (state_q != ST_IDLE);
   assign act_rd_en   = fetch;
   assign w_rd_en     = fetch;
   assign act_rd_addr = fetch ? cnt_q : '0;
   assign w_rd_addr   = fetch ? cnt_q : '0;
   assign pe_in       = pe_in_q;
   assign pe_w        = pe_w_q;
   assign pe_load_n   = pe_load_n_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_fcl_ctrl.sv
// Bench for fp_fcl_ctrl with behavioural RAMs and PE array; results are
// checked against hand-computed lane sums queued when each job is issued.
module tb_fp_fcl_ctrl;
   import fp_fcl_pkg::*;

   localparam int PAR     = 4;
   localparam int DW      = 8;
   localparam int MAX_LEN = 256;
   localparam int AW      = 8;
   localparam int BW      = PAR * DW;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW:0]   len;
   logic          busy;
   logic          act_rd_en;
   logic [AW-1:0] act_rd_addr;
   logic [DW-1:0] act_rd_data;
   logic          w_rd_en;
   logic [AW-1:0] w_rd_addr;
   logic [BW-1:0] w_rd_data;
   logic [DW-1:0] pe_in;
   logic [BW-1:0] pe_w;
   logic          pe_load_n;
   logic [BW-1:0] pe_out;
   logic          res_valid;
   logic          res_ready;
   logic [BW-1:0] res_data;
   logic [1:0]    dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] mon_exp;

   logic [DW-1:0] act_mem [MAX_LEN];
   logic [BW-1:0] w_mem   [MAX_LEN];
   logic [DW-1:0] acc     [PAR] = '{8'h55, 8'h55, 8'h55, 8'h55};

   fp_fcl_ctrl #(
      .PAR       (PAR),
      .DATAWIDTH (DW),
      .MAX_LEN   (MAX_LEN),
      .ADDR_W    (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .len         (len),
      .busy        (busy),
      .act_rd_en   (act_rd_en),
      .act_rd_addr (act_rd_addr),
      .act_rd_data (act_rd_data),
      .w_rd_en     (w_rd_en),
      .w_rd_addr   (w_rd_addr),
      .w_rd_data   (w_rd_data),
      .pe_in       (pe_in),
      .pe_w        (pe_w),
      .pe_load_n   (pe_load_n),
      .pe_out      (pe_out),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous RAMs and the PE array (wraps mod 2^DW, never reset)
   always @(posedge clk) begin
      if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
      if (w_rd_en)   w_rd_data   <= w_mem[w_rd_addr];
   end

   always @(posedge clk) begin
      for (int i = 0; i < PAR; i++) begin
         if (!pe_load_n) acc[i] <= DW'(pe_in * pe_w[i*DW +: DW]);
         else            acc[i] <= DW'(acc[i] + DW'(pe_in * pe_w[i*DW +: DW]));
      end
   end

   always_comb begin
      pe_out = '0;
      for (int i = 0; i < PAR; i++) pe_out[i*DW +: DW] = acc[i];
   end

   task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
      end
   endtask

   // monitor: every accepted result is compared with the head of the queue
   always @(negedge clk) begin
      if (rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_unexpected: got %h required no result", res_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("res_data", res_data, mon_exp);
         end
      end
   end

   // driver tasks
   task automatic clear_mem();
      for (int i = 0; i < MAX_LEN; i++) begin
         act_mem[i] = '0;
         w_mem[i]   = '0;
      end
   endtask

   task automatic set_elem(input int k, input logic [DW-1:0] a, input logic [BW-1:0] w);
      act_mem[k] = a;
      w_mem[k]   = w;
   endtask

   task automatic start_job(input int l);
      start = 1'b1;
      len   = 9'(l);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Issues a job and checks the cycle-by-cycle protocol assuming an empty
   // result buffer; spam holds start high while the job is still running.
   task automatic run_job(input int l, input bit spam);
      start_job(l);
      for (int c = 1; c <= l + 4; c++) begin
         @(negedge clk);
         chk("busy", {31'b0, busy}, {31'b0, (c <= l + 3)});
         chk("act_rd_en", {31'b0, act_rd_en}, {31'b0, (c <= l)});
         chk("w_rd_en", {31'b0, w_rd_en}, {31'b0, (c <= l)});
         chk("act_rd_addr", {24'b0, act_rd_addr}, (c <= l) ? BW'(c - 1) : '0);
         chk("w_rd_addr", {24'b0, w_rd_addr}, (c <= l) ? BW'(c - 1) : '0);
         chk("pe_load_n", {31'b0, pe_load_n}, {31'b0, (c != 3)});
         chk("res_valid", {31'b0, res_valid}, {31'b0, (c == l + 4)});
         if (c < 3 || c > l + 2) begin
            chk("pe_in_gate", {24'b0, pe_in}, '0);
            chk("pe_w_gate", pe_w, '0);
         end
         if (spam) begin
            start = (c <= l + 2);
            len   = 9'd1;
         end
      end
      start = 1'b0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_busy", {31'b0, busy}, '0);
      chk("rst_act_rd_en", {31'b0, act_rd_en}, '0);
      chk("rst_w_rd_en", {31'b0, w_rd_en}, '0);
      chk("rst_act_addr", {24'b0, act_rd_addr}, '0);
      chk("rst_w_addr", {24'b0, w_rd_addr}, '0);
      chk("rst_pe_in", {24'b0, pe_in}, '0);
      chk("rst_pe_w", pe_w, '0);
      chk("rst_pe_load_n", {31'b0, pe_load_n}, 32'd1);
      chk("rst_res_valid", {31'b0, res_valid}, '0);
      chk("rst_res_data", res_data, '0);
      chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
   endtask

   initial begin
      int bad_len [3];
      logic [BW-1:0] big_res;
      bad_len = '{0, 300, 257};
      rst       = 1'b0;
      start     = 1'b0;
      len       = '0;
      res_ready = 1'b1;
      clear_mem();
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b1;
      @(negedge clk);

      // len=3 with a negative weight in lane 1
      clear_mem();
      set_elem(0, 8'd1, {8'd0, 8'd0, 8'd2,   8'd1});
      set_elem(1, 8'd2, {8'd0, 8'd0, 8'hFF,  8'd1});
      set_elem(2, 8'd3, {8'd0, 8'd0, 8'd4,   8'd1});
      exp_q.push_back(32'h0000_0C06);
      run_job(3, 1'b0);
      repeat (2) @(negedge clk);

      // len=1, product wraps to 0x80
      clear_mem();
      set_elem(0, 8'd16, {8'd0, 8'd0, 8'd0, 8'd8});
      exp_q.push_back(32'h0000_0080);
      run_job(1, 1'b0);
      repeat (2) @(negedge clk);

      // illegal lengths are ignored
      foreach (bad_len[i]) begin
         start = 1'b1;
         len   = 9'(bad_len[i]);
         @(negedge clk);
         chk("badlen_busy", {31'b0, busy}, '0);
         chk("badlen_rd_en", {31'b0, act_rd_en | w_rd_en}, '0);
         chk("badlen_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      end
      start = 1'b0;
      @(negedge clk);

      // start held high while busy is ignored
      clear_mem();
      set_elem(0, 8'd1, {8'h10, 8'd0, 8'd0, 8'd1});
      set_elem(1, 8'd1, {8'h10, 8'd0, 8'd0, 8'd2});
      set_elem(2, 8'd1, {8'h10, 8'd0, 8'd0, 8'd3});
      set_elem(3, 8'd1, {8'h10, 8'd0, 8'd0, 8'd4});
      exp_q.push_back(32'h4000_000A);
      run_job(4, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("spam_busy", {31'b0, busy}, '0);
         chk("spam_res_valid", {31'b0, res_valid}, '0);
      end

      // back-to-back jobs under backpressure
      res_ready = 1'b0;
      clear_mem();
      set_elem(0, 8'd1, {8'd0, 8'd0, 8'd3, 8'd1});
      set_elem(1, 8'd2, {8'd0, 8'd0, 8'd1, 8'd2});
      exp_q.push_back(32'h0000_0505);
      run_job(2, 1'b0);
      clear_mem();
      set_elem(0, 8'd2, {8'hFF, 8'd5, 8'd0, 8'd1});
      set_elem(1, 8'd3, {8'hFF, 8'd0, 8'd0, 8'd1});
      set_elem(2, 8'd1, {8'hFF, 8'd0, 8'd0, 8'd1});
      exp_q.push_back(32'hFA0A_0006);
      start_job(3);
      repeat (12) @(negedge clk);
      chk("b2b_busy", {31'b0, busy}, 32'd1);
      chk("b2b_state", {30'b0, dbg_state}, {30'b0, ST_CAPTURE});
      chk("b2b_valid", {31'b0, res_valid}, 32'd1);
      chk("b2b_hold_a", res_data, 32'h0000_0505);
      chk("b2b_pe_in", {24'b0, pe_in}, '0);
      @(posedge clk);
      #1 res_ready = 1'b1;
      repeat (2) @(negedge clk);
      @(negedge clk);
      chk("b2b_done_valid", {31'b0, res_valid}, '0);
      chk("b2b_done_busy", {31'b0, busy}, '0);

      // full-length vector, lane 0 wraps to zero
      clear_mem();
      for (int k = 0; k < MAX_LEN; k++) set_elem(k, 8'd1, {8'd0, 8'd0, 8'd0, 8'd1});
      w_mem[0]   = {8'd0, 8'd1, 8'd0, 8'd1};
      w_mem[255] = {8'd0, 8'd0, 8'd3, 8'd1};
      exp_q.push_back(32'h0001_0300);
      big_res = '0;
      run_job(MAX_LEN, 1'b0);
      big_res = res_data;
      chk("max_lane0", {24'b0, lane_of(big_res, 0)}, '0);
      repeat (2) @(negedge clk);

      // reset mid-FETCH discards a pending result and the partial job
      res_ready = 1'b0;
      clear_mem();
      for (int k = 0; k < 10; k++) set_elem(k, 8'd9, {8'd1, 8'd1, 8'd1, 8'd1});
      run_job(1, 1'b0);
      start_job(10);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_outputs();
      @(negedge clk);
      rst       = 1'b1;
      res_ready = 1'b1;
      clear_mem();
      set_elem(0, 8'd3, {8'd0, 8'd0, 8'd0, 8'd1});
      set_elem(1, 8'd4, {8'd0, 8'd0, 8'd0, 8'd1});
      exp_q.push_back(32'h0000_0007);
      @(negedge clk);
      run_job(2, 1'b0);
      repeat (3) @(negedge clk);

      chk("queue_empty", BW'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
